// File: rtl/tri_bus_pkg.sv
// Shared types and width helper for the tri-state bus controller.
// Purely declarative: no logic, no latency.
package tri_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      TURN  = 2'd2
   } state_t;

   // Index/counter width that stays >= 1 even for degenerate counts.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tri_bus_ctrl_if.sv
// Requester-side bundle of the shared-bus controller: per-channel req/wdata in,
// registered grant, combinational bus drive and beat strobes out.
interface tri_bus_ctrl_if #(
   parameter int N_CH   = 4,
   parameter int DATA_W = 8
);

   logic [N_CH-1:0]        req;
   logic [N_CH*DATA_W-1:0] wdata;
   logic [N_CH-1:0]        grant;
   logic                   bus_oe;
   logic [DATA_W-1:0]      bus_out;
   logic [N_CH-1:0]        beat;

   modport master (
      output req, wdata,
      input  grant, bus_oe, bus_out, beat
   );

   modport slave (
      input  req, wdata,
      output grant, bus_oe, bus_out, beat
   );

endinterface

// File: rtl/tri_bus_ctrl_rr_arbiter.sv
// Round-robin pick: first requester after last_owner, wrapping. Combinational,
// zero latency; valid=0 when nobody requests.
module rr_arbiter
   import tri_bus_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int OW   = cnt_w(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [OW-1:0]   last_owner,
   output logic [OW-1:0]   winner,
   output logic            valid
);

   logic [OW-1:0] cand;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int k = 1; k <= N_CH; k++) begin
         cand = OW'((int'(last_owner) + k) % N_CH);
         if (!valid && req[cand]) begin
            valid  = 1'b1;
            winner = cand;
         end
      end
   end

endmodule

// File: rtl/tri_bus_ctrl.sv
// Round-robin tri-state bus owner: grant one cycle after req in IDLE, bus drive follows owner req
// combinationally. Bursts capped at MAX_BEATS with TA_CYC released cycles between owners; TRI_BUS_PAD_EN adds bus_io/rd_data.
module tri_bus_ctrl
   import tri_bus_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BEATS = 4,
   parameter int TA_CYC    = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   tri_bus_ctrl_if.slave  bus
`ifdef TRI_BUS_PAD_EN
   ,
   inout  wire  [DATA_W-1:0] bus_io,
   output logic [DATA_W-1:0] rd_data
`endif
);

   localparam int OW = cnt_w(N_CH);
   localparam int BW = cnt_w(MAX_BEATS);
   localparam int TW = cnt_w(TA_CYC);
   localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BEATS - 1);
   localparam logic [TW-1:0] TA_LAST   = TW'((TA_CYC > 0) ? TA_CYC - 1 : 0);

   state_t            state, state_nx;
   logic [N_CH-1:0]   grant_q, grant_nx;
   logic [OW-1:0]     last_owner, last_owner_nx;
   logic [BW-1:0]     beat_cnt, beat_cnt_nx;
   logic [TW-1:0]     ta_cnt, ta_cnt_nx;
   logic [OW-1:0]     arb_win;
   logic              arb_vld;
   logic              take_arb;
   logic              drive_exit;
   logic              owner_req;
   logic              drive_on;
   logic [DATA_W-1:0] ch_dat [N_CH];

   rr_arbiter #(
      .N_CH (N_CH),
      .OW   (OW)
   ) u_arb (
      .req        (bus.req),
      .last_owner (last_owner),
      .winner     (arb_win),
      .valid      (arb_vld)
   );

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         ch_dat[i] = bus.wdata[i*DATA_W +: DATA_W];
      end
   end

   // last_owner doubles as the current owner index while in DRIVE.
   assign owner_req = bus.req[last_owner];
   assign drive_on  = (state == DRIVE) && owner_req;

   assign bus.grant   = grant_q;
   assign bus.bus_oe  = drive_on;
   assign bus.bus_out = drive_on ? ch_dat[last_owner] : '0;
   assign bus.beat    = drive_on ? grant_q : '0;

   always_comb begin
      state_nx      = state;
      grant_nx      = grant_q;
      last_owner_nx = last_owner;
      beat_cnt_nx   = beat_cnt;
      ta_cnt_nx     = ta_cnt;
      take_arb      = 1'b0;
      drive_exit    = 1'b0;

      unique case (state)
         IDLE: begin
            take_arb = 1'b1;
         end
         DRIVE: begin
            if (!owner_req) begin
               drive_exit = 1'b1;
            end else if (beat_cnt == BEAT_LAST) begin
               drive_exit = 1'b1;
            end else begin
               beat_cnt_nx = beat_cnt + BW'(1);
            end
            if (drive_exit) begin
               grant_nx  = '0;
               ta_cnt_nx = '0;
               state_nx  = TURN;
               // With no turnaround the exit edge hands over directly.
               take_arb  = (TA_CYC == 0);
            end
         end
         TURN: begin
            if (ta_cnt == TA_LAST) begin
               take_arb = 1'b1;
            end else begin
               ta_cnt_nx = ta_cnt + TW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      if (take_arb) begin
         if (arb_vld) begin
            state_nx      = DRIVE;
            grant_nx      = N_CH'(1) << arb_win;
            last_owner_nx = arb_win;
            beat_cnt_nx   = '0;
         end else begin
            state_nx = IDLE;
         end
      end
   end

   // Reset puts last_owner on the top channel so channel 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant_q    <= '0;
         last_owner <= OW'(N_CH - 1);
         beat_cnt   <= '0;
         ta_cnt     <= '0;
      end else begin
         state      <= state_nx;
         grant_q    <= grant_nx;
         last_owner <= last_owner_nx;
         beat_cnt   <= beat_cnt_nx;
         ta_cnt     <= ta_cnt_nx;
      end
   end

`ifdef TRI_BUS_PAD_EN
   assign bus_io = drive_on ? bus.bus_out : {DATA_W{1'bz}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (!drive_on) begin
         rd_data <= bus_io;
      end
   end
`endif

endmodule
